// File: rtl/ram_preload_sequencer.sv
// Copies the loader's CNN image, then its FC image, into the weight RAMs one word
// per cycle, reading the loader buffers through their 1-cycle read latency.
module ram_preload_sequencer #(
    parameter int DW        = 16,
    parameter int CNN_WORDS = 50704,
    parameter int FC_WORDS  = 11218,
    parameter int CNN_AW    = 16,
    parameter int FC_AW     = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic [CNN_AW-1:0] cnn_rd_addr,
    input  logic [DW-1:0]     cnn_rd_data,
    output logic [FC_AW-1:0]  fc_rd_addr,
    input  logic [DW-1:0]     fc_rd_data,
    output logic              cnn_wr_en,
    output logic [CNN_AW-1:0] cnn_wr_addr,
    output logic [DW-1:0]     cnn_wr_data,
    output logic              fc_wr_en,
    output logic [FC_AW-1:0]  fc_wr_addr,
    output logic [DW-1:0]     fc_wr_data,
    output logic              busy,
    output logic              done
);

    localparam logic [CNN_AW-1:0] CNN_LAST = (CNN_WORDS == 0) ? '0 : CNN_AW'(CNN_WORDS - 1);
    localparam logic [FC_AW-1:0]  FC_LAST  = (FC_WORDS == 0)  ? '0 : FC_AW'(FC_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CNN, S_FC, S_DONE} state_t;

    state_t          state, state_nxt;
    logic            cnn_valid, cnn_held, fc_valid, fc_held;
    logic [DW-1:0]   cnn_skid, fc_skid;
    logic            cnn_last_wr, fc_last_wr;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CNN;
            S_CNN:   if (CNN_WORDS == 0 || cnn_last_wr) state_nxt = S_FC;
            S_FC:    if (FC_WORDS == 0 || fc_last_wr) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_CNN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The word on rd_data when hold rises belongs to wr_addr, but the registered
    // rd_addr has already moved on; it is parked here and written once hold drops.
    always_comb begin
        busy        = (state == S_CNN) || (state == S_FC);
        done        = (state == S_DONE);
        cnn_wr_en   = (state == S_CNN) && cnn_valid && !hold;
        fc_wr_en    = (state == S_FC) && fc_valid && !hold;
        cnn_last_wr = cnn_wr_en && (cnn_wr_addr == CNN_LAST);
        fc_last_wr  = fc_wr_en && (fc_wr_addr == FC_LAST);
        cnn_wr_data = cnn_held ? cnn_skid : cnn_rd_data;
        fc_wr_data  = fc_held ? fc_skid : fc_rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst || state != S_CNN) begin
            cnn_rd_addr <= '0;
            cnn_wr_addr <= '0;
            cnn_valid   <= 1'b0;
            cnn_held    <= 1'b0;
        end else if (hold) begin
            if (cnn_valid && !cnn_held) begin
                cnn_held <= 1'b1;
                cnn_skid <= cnn_rd_data;
            end
        end else begin
            cnn_valid   <= 1'b1;
            cnn_held    <= 1'b0;
            cnn_wr_addr <= cnn_rd_addr;
            if (cnn_rd_addr != CNN_LAST) cnn_rd_addr <= cnn_rd_addr + CNN_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state != S_FC) begin
            fc_rd_addr <= '0;
            fc_wr_addr <= '0;
            fc_valid   <= 1'b0;
            fc_held    <= 1'b0;
        end else if (hold) begin
            if (fc_valid && !fc_held) begin
                fc_held <= 1'b1;
                fc_skid <= fc_rd_data;
            end
        end else begin
            fc_valid   <= 1'b1;
            fc_held    <= 1'b0;
            fc_wr_addr <= fc_rd_addr;
            if (fc_rd_addr != FC_LAST) fc_rd_addr <= fc_rd_addr + FC_AW'(1);
        end
    end

endmodule

// File: tb/tb_ram_preload_sequencer.sv
// Bench for ram_preload_sequencer: vector table, directed corner sequences, random
// start/hold/rst against a phase-level reference model, and one full-size copy.
module tb_ram_preload_sequencer;

    logic clk = 1'b0;
    logic rst, start, hold, rst_c, start_c;
    int   total = 0;
    int   bad = 0;
    bit   armed = 1'b0;

    always #5 clk = ~clk;

    // small instance A: 4 CNN words, 3 FC words
    logic [2:0]  a_cra, a_cwa;
    logic [1:0]  a_fra, a_fwa;
    logic [15:0] a_crd, a_frd, a_cwd, a_fwd;
    logic        a_cwe, a_fwe, a_busy, a_done;
    // instance B: 4 CNN words, zero-length FC phase
    logic [2:0]  b_cra, b_cwa;
    logic [1:0]  b_fra, b_fwa;
    logic [15:0] b_crd, b_frd, b_cwd, b_fwd;
    logic        b_cwe, b_fwe, b_busy, b_done;
    // instance C: default sizes
    logic [15:0] c_cra, c_cwa;
    logic [13:0] c_fra, c_fwa;
    logic [15:0] c_crd, c_frd, c_cwd, c_fwd;
    logic        c_cwe, c_fwe, c_busy, c_done;

    ram_preload_sequencer #(.DW(16), .CNN_WORDS(4), .FC_WORDS(3), .CNN_AW(3), .FC_AW(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .cnn_rd_addr(a_cra), .cnn_rd_data(a_crd), .fc_rd_addr(a_fra), .fc_rd_data(a_frd),
        .cnn_wr_en(a_cwe), .cnn_wr_addr(a_cwa), .cnn_wr_data(a_cwd),
        .fc_wr_en(a_fwe), .fc_wr_addr(a_fwa), .fc_wr_data(a_fwd),
        .busy(a_busy), .done(a_done));

    ram_preload_sequencer #(.DW(16), .CNN_WORDS(4), .FC_WORDS(0), .CNN_AW(3), .FC_AW(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .cnn_rd_addr(b_cra), .cnn_rd_data(b_crd), .fc_rd_addr(b_fra), .fc_rd_data(b_frd),
        .cnn_wr_en(b_cwe), .cnn_wr_addr(b_cwa), .cnn_wr_data(b_cwd),
        .fc_wr_en(b_fwe), .fc_wr_addr(b_fwa), .fc_wr_data(b_fwd),
        .busy(b_busy), .done(b_done));

    ram_preload_sequencer dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .hold(1'b0),
        .cnn_rd_addr(c_cra), .cnn_rd_data(c_crd), .fc_rd_addr(c_fra), .fc_rd_data(c_frd),
        .cnn_wr_en(c_cwe), .cnn_wr_addr(c_cwa), .cnn_wr_data(c_cwd),
        .fc_wr_en(c_fwe), .fc_wr_addr(c_fwa), .fc_wr_data(c_fwd),
        .busy(c_busy), .done(c_done));

    // loader buffers with 1-cycle read latency
    always @(posedge clk) begin
        a_crd <= 16'h1000 + 16'(a_cra);
        a_frd <= 16'h2000 + 16'(a_fra);
        b_crd <= 16'h1000 + 16'(b_cra);
        b_frd <= 16'h2000 + 16'(b_fra);
        c_crd <= 16'h1000 + c_cra;
        c_frd <= 16'h2000 + 16'(c_fra);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: phase 0 idle, 1 cnn, 2 fc, 3 done; cnt = non-hold cycles spent in phase.
    task automatic model_step(inout int ph, inout int cnt, input int nc, input int nf,
                              input logic rs, input logic st, input logic hd);
        int n;
        if (rs) begin
            ph = 0; cnt = 0;
        end else if (ph == 1 || ph == 2) begin
            n = (ph == 1) ? nc : nf;
            if (n == 0) begin
                ph++; cnt = 0;
            end else if (!hd) begin
                cnt++;
                if (cnt == n + 1) begin ph++; cnt = 0; end
            end
        end else if (st) begin
            ph = 1; cnt = 0;
        end
    endtask

    task automatic model_check(input string tag, input int ph, input int cnt, input int nc,
                               input int nf, input logic hd, input logic busy, input logic done,
                               input logic cwe, input int cwa, input int cra, input int cwd,
                               input logic fwe, input int fwa, input int fra, input int fwd);
        logic ecwe, efwe;
        ecwe = (ph == 1) && !hd && (cnt >= 1);
        efwe = (ph == 2) && !hd && (cnt >= 1);
        chk({tag, "_busy"}, busy, (ph == 1 || ph == 2));
        chk({tag, "_done"}, done, (ph == 3));
        chk({tag, "_cnn_wr_en"}, cwe, ecwe);
        chk({tag, "_fc_wr_en"}, fwe, efwe);
        if (ecwe && cwe) begin
            chk({tag, "_cnn_wr_addr"}, cwa, cnt - 1);
            chk({tag, "_cnn_wr_data"}, cwd, (32'h1000 + cnt - 1) & 32'hffff);
        end
        if (efwe && fwe) begin
            chk({tag, "_fc_wr_addr"}, fwa, cnt - 1);
            chk({tag, "_fc_wr_data"}, fwd, (32'h2000 + cnt - 1) & 32'hffff);
        end
        if (ph == 1 && nc > 0) chk({tag, "_cnn_rd_addr"}, cra, (cnt < nc - 1) ? cnt : nc - 1);
        if (ph == 2 && nf > 0) chk({tag, "_fc_rd_addr"}, fra, (cnt < nf - 1) ? cnt : nf - 1);
    endtask

    int ma_ph = 0, ma_cnt = 0, mb_ph = 0, mb_cnt = 0;

    always @(posedge clk) begin
        model_step(ma_ph, ma_cnt, 4, 3, rst, start, hold);
        model_step(mb_ph, mb_cnt, 4, 0, rst, start, hold);
    end

    always @(negedge clk) begin
        if (armed) begin
            model_check("A", ma_ph, ma_cnt, 4, 3, hold, a_busy, a_done, a_cwe, a_cwa, a_cra,
                        a_cwd, a_fwe, a_fwa, a_fra, a_fwd);
            model_check("B", mb_ph, mb_cnt, 4, 0, hold, b_busy, b_done, b_cwe, b_cwa, b_cra,
                        b_cwd, b_fwe, b_fwa, b_fra, b_fwd);
        end
    end

    typedef struct {
        logic st, hd, busy, done, cwe;
        int   caddr, cdata;
        logic fwe;
        int   faddr, fdata;
    } vec_t;

    function automatic vec_t mk(logic st, logic hd, logic busy, logic done, logic cwe,
                                int caddr, int cdata, logic fwe, int faddr, int fdata);
        vec_t v;
        v.st = st; v.hd = hd; v.busy = busy; v.done = done; v.cwe = cwe;
        v.caddr = caddr; v.cdata = cdata; v.fwe = fwe; v.faddr = faddr; v.fdata = fdata;
        return v;
    endfunction

    task automatic step(input logic st, input logic hd, input logic rs);
        @(posedge clk);
        #1;
        start = st; hold = hd; rst = rs;
        @(negedge clk);
    endtask

    vec_t tbl[12];
    int   b_fc_writes, b_done_at, w0, w1, nw, held_wr, done_at;
    int   c_cn, c_fn, c_err, c_both, c_done_at;

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0,       0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0,       0, 0, 0);
        tbl[2]  = mk(0, 0, 1, 0, 1, 0, 'h1000,  0, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 1, 1, 'h1001,  0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 1, 2, 'h1002,  0, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 1, 3, 'h1003,  0, 0, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0, 0,       0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0,       1, 0, 'h2000);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0,       1, 1, 'h2001);
        tbl[9]  = mk(0, 0, 1, 0, 0, 0, 0,       1, 2, 'h2002);
        tbl[10] = mk(0, 0, 0, 1, 0, 0, 0,       0, 0, 0);
        tbl[11] = mk(0, 0, 0, 1, 0, 0, 0,       0, 0, 0);

        rst = 1'b1; start = 1'b0; hold = 1'b0; rst_c = 1'b1; start_c = 1'b0;
        step(0, 0, 1);
        step(0, 0, 1);
        armed = 1'b1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_cnn_wr_en", a_cwe, 0);
        chk("rst_fc_wr_en", a_fwe, 0);
        chk("rst_cnn_rd_addr", a_cra, 0);
        chk("rst_fc_rd_addr", a_fra, 0);

        // basic copy from the vector table; B runs the same stimulus with no FC phase
        b_fc_writes = 0; b_done_at = -1;
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].st, tbl[k].hd, 0);
            chk($sformatf("tbl%0d_busy", k), a_busy, tbl[k].busy);
            chk($sformatf("tbl%0d_done", k), a_done, tbl[k].done);
            chk($sformatf("tbl%0d_cnn_wr_en", k), a_cwe, tbl[k].cwe);
            chk($sformatf("tbl%0d_fc_wr_en", k), a_fwe, tbl[k].fwe);
            if (tbl[k].cwe) begin
                chk($sformatf("tbl%0d_cnn_wr_addr", k), a_cwa, tbl[k].caddr);
                chk($sformatf("tbl%0d_cnn_wr_data", k), a_cwd, tbl[k].cdata);
            end
            if (tbl[k].fwe) begin
                chk($sformatf("tbl%0d_fc_wr_addr", k), a_fwa, tbl[k].faddr);
                chk($sformatf("tbl%0d_fc_wr_data", k), a_fwd, tbl[k].fdata);
            end
            if (b_fwe) b_fc_writes++;
            if (b_done && b_done_at < 0) b_done_at = k;
        end
        chk("zero_fc_writes", b_fc_writes, 0);
        chk("zero_fc_done_cycle", b_done_at, 7);

        // hold in cycles 3..5
        step(0, 0, 1);
        w0 = -1; w1 = -1; nw = 0; held_wr = 0; done_at = -1;
        for (int k = 0; k < 16; k++) begin
            step(k == 0, (k >= 3 && k <= 5), 0);
            if (a_cwe && a_cwd == 16'h1000) w0 = k;
            if (a_cwe && a_cwd == 16'h1001) w1 = k;
            if (a_cwe || a_fwe) nw++;
            if ((a_cwe || a_fwe) && k >= 3 && k <= 5) held_wr++;
            if (a_done && done_at < 0) done_at = k;
        end
        chk("hold_first_write_cycle", w0, 2);
        chk("hold_second_write_cycle", w1, 6);
        chk("hold_writes_during_hold", held_wr, 0);
        chk("hold_total_writes", nw, 7);
        chk("hold_done_cycle", done_at, 13);

        // rst mid-CNN, then a fresh copy
        step(0, 0, 1);
        for (int k = 0; k < 6; k++) step(k == 0, 0, k == 4);
        chk("midrst_busy", a_busy, 0);
        chk("midrst_done", a_done, 0);
        chk("midrst_cnn_wr_en", a_cwe, 0);
        chk("midrst_cnn_rd_addr", a_cra, 0);
        chk("midrst_cnn_wr_addr", a_cwa, 0);
        for (int k = 0; k < 3; k++) step(k == 0, 0, 0);
        chk("recopy_cnn_wr_en", a_cwe, 1);
        chk("recopy_cnn_wr_addr", a_cwa, 0);
        chk("recopy_cnn_wr_data", a_cwd, 'h1000);

        // start while busy is ignored; start after done re-copies
        step(0, 0, 1);
        nw = 0; done_at = -1;
        for (int k = 0; k < 15; k++) begin
            step(k == 0 || k == 3 || k == 12, 0, 0);
            if (k < 12 && (a_cwe || a_fwe)) nw++;
            if (a_done && done_at < 0) done_at = k;
            if (k == 13) begin
                chk("restart_done_drop", a_done, 0);
                chk("restart_busy", a_busy, 1);
            end
            if (k == 14) begin
                chk("restart_cnn_wr_en", a_cwe, 1);
                chk("restart_cnn_wr_addr", a_cwa, 0);
            end
        end
        chk("busy_start_writes", nw, 7);
        chk("busy_start_done_cycle", done_at, 10);

        // randomized start/hold/rst against the reference model
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);

        // full-size copy on the default instance
        @(posedge clk); #1; rst_c = 1'b1;
        @(posedge clk); #1; rst_c = 1'b0; start_c = 1'b1;
        c_cn = 0; c_fn = 0; c_err = 0; c_both = 0; c_done_at = -1;
        for (int k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (c_cwe && c_fwe) c_both++;
            if (c_cwe) begin
                if (int'(c_cwa) != c_cn || c_cwd != 16'(32'h1000 + c_cn)) c_err++;
                c_cn++;
            end
            if (c_fwe) begin
                if (int'(c_fwa) != c_fn || c_fwd != 16'(32'h2000 + c_fn)) c_err++;
                c_fn++;
            end
            if (c_done) begin
                c_done_at = k;
                break;
            end
            @(posedge clk); #1; start_c = 1'b0;
        end
        chk("full_cnn_writes", c_cn, 50704);
        chk("full_fc_writes", c_fn, 11218);
        chk("full_order_errors", c_err, 0);
        chk("full_both_wr_en", c_both, 0);
        chk("full_done_cycle", c_done_at, 50704 + 11218 + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
